// File: rtl/bcd_display_mux_if.sv
// Interface for bcd_display_mux: capture strobe, BCD digits and error flag in,
// multiplexed 7-segment pattern, digit enables and loaded flag out.
interface bcd_display_mux_if;
    logic       load;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       error;
    logic [6:0] seg;
    logic [1:0] an;
    logic       loaded;

    // Upstream adder side
    modport master (
        output load, digit0, digit1, error,
        input  seg, an, loaded
    );

    // Display driver side
    modport slave (
        input  load, digit0, digit1, error,
        output seg, an, loaded
    );
endinterface

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: latches a two-digit BCD result plus error flag on a load
// strobe and time-multiplexes it onto a common-segment 7-segment pair.
// Optional feature macro: DISPLAY_BLINK_EN (blinks the 'E' display on error).
module bcd_display_mux #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic             clk,
    input  logic             reset,
    bcd_display_mux_if.slave bus
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    // Reject degenerate configurations at elaboration
    if (REFRESH_DIV < 1) begin : g_bad_refresh
        $error("REFRESH_DIV must be >= 1");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("BLINK_DIV must be >= 1");
    end

    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic [3:0]    r_d0;
    logic [3:0]    r_d1;
    logic          r_err;
    logic          r_loaded;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_slot_end;
    logic [3:0]    w_digit;
    logic [6:0]    w_pat;
    logic [6:0]    w_seg_next;
    logic [1:0]    w_an_next;
    logic          w_blink_on;

    assign w_slot_end = (r_cnt == CNT_LAST);

    // Free-running slot counter; load never disturbs the refresh cadence
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_sel <= ~r_sel;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Capture adder result on the load strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0     <= '0;
            r_d1     <= '0;
            r_err    <= 1'b0;
            r_loaded <= 1'b0;
        end else if (bus.load) begin
            r_d0     <= bus.digit0;
            r_d1     <= bus.digit1;
            r_err    <= bus.error;
            r_loaded <= 1'b1;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    // Blink phase counts slot toggles while an error is held; restarts on every load
    always_ff @(posedge clk) begin
        if (reset || bus.load || !r_err) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_slot_end) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_blink_on = r_blink_on;
`else
    assign w_blink_on = 1'b1;
`endif

    // Segment decode of the digit selected for the current slot
    always_comb begin
        w_pat   = SEG_DASH;
        w_digit = r_sel ? r_d1 : r_d0;
        case (w_digit)
            4'd0:    w_pat = 7'b1111110;
            4'd1:    w_pat = 7'b0110000;
            4'd2:    w_pat = 7'b1101101;
            4'd3:    w_pat = 7'b1111001;
            4'd4:    w_pat = 7'b0110011;
            4'd5:    w_pat = 7'b1011011;
            4'd6:    w_pat = 7'b1011111;
            4'd7:    w_pat = 7'b1110000;
            4'd8:    w_pat = 7'b1111111;
            4'd9:    w_pat = 7'b1111011;
            default: w_pat = SEG_DASH;
        endcase
    end

    // Next display drive: blank until first load, 'E' overrides digits on error
    always_comb begin
        w_seg_next = '0;
        w_an_next  = '0;
        if (r_loaded) begin
            w_seg_next = r_err ? SEG_E : w_pat;
            w_an_next  = r_sel ? 2'b10 : 2'b01;
            if (!w_blink_on) begin
                w_an_next = '0;
            end
        end
    end

    // Registered outputs; segment and enable always update together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= '0;
            r_an  <= '0;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.seg    = r_seg;
    assign bus.an     = r_an;
    assign bus.loaded = r_loaded;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed self-checking bench for bcd_display_mux with REFRESH_DIV=4, BLINK_DIV=2.
module tb_bcd_display_mux;

    localparam int RD = 4;
    localparam int BD = 2;
    localparam logic [6:0] SEG_E = 7'b1001111;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bcd_display_mux_if bus ();

    bcd_display_mux #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference state: edges since last reset, held data, edge of last load
    int         n_edge    = 0;
    int         load_edge = 0;
    logic       m_loaded  = 1'b0;
    logic       m_err     = 1'b0;
    logic [3:0] m_d0      = '0;
    logic [3:0] m_d1      = '0;

    logic [6:0] e_seg    = '0;
    logic [1:0] e_an     = '0;
    logic       e_loaded = 1'b0;

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    // One clock edge: expected outputs come from the state held before the edge
    task automatic tick();
        logic sel;
        int   toggles;
        if (reset || !m_loaded) begin
            e_seg = '0;
            e_an  = '0;
        end else begin
            sel   = ((n_edge / RD) % 2) == 1;
            e_seg = m_err ? SEG_E : pat(sel ? m_d1 : m_d0);
            e_an  = sel ? 2'b10 : 2'b01;
`ifdef DISPLAY_BLINK_EN
            toggles = (n_edge / RD) - (load_edge / RD);
            if (m_err && ((toggles / BD) % 2) == 1) e_an = '0;
`else
            toggles = 0;
`endif
        end
        if (reset) begin
            n_edge   = 0;
            m_loaded = 1'b0;
            m_err    = 1'b0;
            m_d0     = '0;
            m_d1     = '0;
        end else begin
            n_edge++;
            if (bus.load) begin
                m_d0      = bus.digit0;
                m_d1      = bus.digit1;
                m_err     = bus.error;
                m_loaded  = 1'b1;
                load_edge = n_edge;
            end
        end
        e_loaded = m_loaded;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        n_total++;
        assert (bus.seg === e_seg) n_pass++;
        else begin n_fail++; $error("FAIL %s seg got %b want %b", tag, bus.seg, e_seg); end
        n_total++;
        assert (bus.an === e_an) n_pass++;
        else begin n_fail++; $error("FAIL %s an got %b want %b", tag, bus.an, e_an); end
        n_total++;
        assert (bus.loaded === e_loaded) n_pass++;
        else begin n_fail++; $error("FAIL %s loaded got %b want %b", tag, bus.loaded, e_loaded); end
    endtask

    task automatic check_lit(input string tag, input logic [6:0] seg, input logic [1:0] an);
        n_total++;
        assert (bus.seg === seg) n_pass++;
        else begin n_fail++; $error("FAIL %s seg got %b want %b", tag, bus.seg, seg); end
        n_total++;
        assert (bus.an === an) n_pass++;
        else begin n_fail++; $error("FAIL %s an got %b want %b", tag, bus.an, an); end
    endtask

    task automatic do_load(input logic [3:0] d0, input logic [3:0] d1, input logic err, input string tag);
        bus.digit0 = d0;
        bus.digit1 = d1;
        bus.error  = err;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        check(tag);
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.digit0 = '0;
        bus.digit1 = '0;
        bus.error  = 1'b0;

        // 1: reset, then idle with no load
        tick();
        tick();
        check("reset");
        reset = 1'b0;
        repeat (24) begin tick(); check("idle"); end

        // 2: load 17 so that the units slot comes up first
        do_load(4'd7, 4'd1, 1'b0, "load17_edge");
        tick();
        check_lit("units7", 7'b1110000, 2'b01);
        tick(); tick(); tick();
        check_lit("tens1", 7'b0110000, 2'b10);
        repeat (12) begin tick(); check("show17"); end

        // 3: error overrides both digits
        do_load(4'd5, 4'd3, 1'b1, "loaderr_edge");
        repeat (10) begin tick(); check("err_E"); end

        // 4: invalid units code shows dash, tens shows 9
        do_load(4'hC, 4'h9, 1'b0, "load9C_edge");
        repeat (10) begin tick(); check("dash9"); end

        // 5: load coincident with slot terminal count entering the units slot
        do_load(4'd8, 4'd0, 1'b0, "load08_edge");
        while (((n_edge + 1) % 8) != 0) begin tick(); check("pre_tc"); end
        do_load(4'd2, 4'd0, 1'b0, "tc_load_edge");
        tick();
        check_lit("tc_units2", 7'b1101101, 2'b01);
        repeat (8) begin
            tick();
            check("post_tc");
            n_total++;
            assert (bus.seg !== 7'b1111111) n_pass++;
            else begin n_fail++; $error("FAIL stale8 seg got %b want not 1111111", bus.seg); end
        end

        // 6: reset mid-slot with data shown
        tick();
        check("pre_rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_lit("rst_mid", 7'b0000000, 2'b00);
        check("rst_mid_all");
        tick();
        check("rst_after");
        do_load(4'd5, 4'd6, 1'b0, "load65_edge");
        repeat (10) begin tick(); check("show65"); end

        // Error held across many slots, loaded on a slot boundary
        while (((n_edge + 1) % 8) != 0) begin tick(); check("pre_blink"); end
        do_load(4'd1, 4'd2, 1'b1, "loaderr2_edge");
        repeat (40) begin tick(); check("err_hold"); end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
